// File: rtl/cpu_types_pkg.sv
// Shared execute-stage types: ALU and multiply/divide operation encodings.
package cpu_types_pkg;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } aluop_t;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } muldiv_op_t;

  function automatic logic md_is_signed(input muldiv_op_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Sign handling around the unsigned iteration core: magnitudes on entry,
// conditional negation of the product, quotient and remainder on the way out.
module muldiv_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  input  logic           i_signed,
  output logic [W-1:0]   o_abs_a,
  output logic [W-1:0]   o_abs_b,
  output logic           o_neg_a,
  output logic           o_neg_b,
  input  logic [2*W-1:0] i_prod,
  input  logic [W-1:0]   i_quo,
  input  logic [W-1:0]   i_rem,
  input  logic           i_neg_res,
  input  logic           i_neg_rem,
  output logic [2*W-1:0] o_prod,
  output logic [W-1:0]   o_quo,
  output logic [W-1:0]   o_rem
);

  assign o_neg_a = i_signed & i_a[W-1];
  assign o_neg_b = i_signed & i_b[W-1];
  // The most-negative value maps onto itself, which is its correct unsigned magnitude.
  assign o_abs_a = o_neg_a ? -i_a : i_a;
  assign o_abs_b = o_neg_b ? -i_b : i_b;

  assign o_prod = i_neg_res ? -i_prod : i_prod;
  assign o_quo  = i_neg_res ? -i_quo  : i_quo;
  assign o_rem  = i_neg_rem ? -i_rem  : i_rem;

endmodule

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle MULT/DIV engine beside the EX-stage ALU; owns HI/LO and stalls the pipe while busy.
// Shift-add multiply retires MUL_BITS bits per cycle, restoring divide retires one quotient bit.
module ex_muldiv_unit
  import cpu_types_pkg::*;
#(
  parameter int WORD_W   = 32,
  parameter int MUL_BITS = 1
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              flush,
  input  logic              start,
  input  muldiv_op_t        op,
  input  logic [WORD_W-1:0] opa,
  input  logic [WORD_W-1:0] opb,
  input  logic              mf_req,
  output logic              busy,
  output logic              stall,
  output logic              done,
  output logic [WORD_W-1:0] hi,
  output logic [WORD_W-1:0] lo
);

  localparam int NMUL  = WORD_W / MUL_BITS;
  localparam int NDIV  = WORD_W;
  localparam int CNT_W = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t              r_state, w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [2*WORD_W-1:0] r_acc;
  logic [WORD_W-1:0]   r_mcand;
  logic                r_is_div, r_neg_res, r_neg_rem, r_dz, r_done;
  logic [WORD_W-1:0]   r_hi, r_lo;

  logic                w_accept, w_is_mul, w_is_div, w_signed, w_last;
  logic [WORD_W-1:0]   w_abs_a, w_abs_b, w_quo, w_rem;
  logic                w_neg_a, w_neg_b;
  logic [2*WORD_W-1:0] w_prod;

  assign w_accept = (r_state == S_IDLE) && start && !flush;
  assign w_is_mul = (op == MD_MULT) || (op == MD_MULTU);
  assign w_is_div = (op == MD_DIV) || (op == MD_DIVU);
  assign w_signed = md_is_signed(op);
  assign w_last   = (r_cnt == CNT_W'(1));

  muldiv_signfix #(.W(WORD_W)) u_signfix (
    .i_a       (opa),
    .i_b       (opb),
    .i_signed  (w_signed),
    .o_abs_a   (w_abs_a),
    .o_abs_b   (w_abs_b),
    .o_neg_a   (w_neg_a),
    .o_neg_b   (w_neg_b),
    .i_prod    (r_acc),
    .i_quo     (r_acc[WORD_W-1:0]),
    .i_rem     (r_acc[2*WORD_W-1:WORD_W]),
    .i_neg_res (r_neg_res),
    .i_neg_rem (r_neg_rem),
    .o_prod    (w_prod),
    .o_quo     (w_quo),
    .o_rem     (w_rem)
  );

  // Multiply: accumulate multiplicand * low digit into the upper half, shift the product right.
  logic [WORD_W+MUL_BITS-1:0] w_partial, w_mulsum;
  logic [2*WORD_W-1:0]        w_mul_next;
  assign w_partial  = {{MUL_BITS{1'b0}}, r_mcand} * {{WORD_W{1'b0}}, r_acc[MUL_BITS-1:0]};
  assign w_mulsum   = {{MUL_BITS{1'b0}}, r_acc[2*WORD_W-1:WORD_W]} + w_partial;
  assign w_mul_next = {w_mulsum, r_acc[WORD_W-1:MUL_BITS]};

  // Divide: the shifted partial remainder needs one extra bit before the trial subtract.
  logic [WORD_W:0]     w_rem_sh;
  logic [WORD_W-1:0]   w_diff;
  logic                w_qbit;
  logic [2*WORD_W-1:0] w_div_next;
  assign w_rem_sh   = {r_acc[2*WORD_W-1:WORD_W], r_acc[WORD_W-1]};
  assign w_qbit     = (w_rem_sh >= {1'b0, r_mcand});
  assign w_diff     = w_rem_sh[WORD_W-1:0] - r_mcand;
  assign w_div_next = {w_qbit ? w_diff : w_rem_sh[WORD_W-1:0], r_acc[WORD_W-2:0], w_qbit};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_is_mul)      w_next = S_MUL;
        else if (w_accept && w_is_div) w_next = S_DIV;
      end
      S_MUL, S_DIV: if (w_last) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_dz      <= 1'b0;
      r_done    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_is_mul) begin
            r_acc     <= {{WORD_W{1'b0}}, w_abs_b};
            r_mcand   <= w_abs_a;
            r_cnt     <= CNT_W'(NMUL);
            r_is_div  <= 1'b0;
            r_neg_res <= w_neg_a ^ w_neg_b;
            r_neg_rem <= 1'b0;
            r_dz      <= 1'b0;
          end else if (w_accept && w_is_div) begin
            r_acc     <= {{WORD_W{1'b0}}, w_abs_a};
            r_mcand   <= w_abs_b;
            r_cnt     <= CNT_W'(NDIV);
            r_is_div  <= 1'b1;
            r_neg_res <= w_neg_a ^ w_neg_b;
            r_neg_rem <= w_neg_a;
            r_dz      <= (opb == '0);
          end else if (w_accept && op == MD_MTHI) begin
            r_hi <= opa;
          end else if (w_accept && op == MD_MTLO) begin
            r_lo <= opa;
          end
        end
        S_MUL: begin
          r_acc <= w_mul_next;
          r_cnt <= r_cnt - CNT_W'(1);
        end
        S_DIV: begin
          r_acc <= w_div_next;
          r_cnt <= r_cnt - CNT_W'(1);
        end
        S_FIX: begin
          // A zero divisor leaves the dividend magnitude as remainder, so sign-fixed it is opa again.
          if (!flush) begin
            if (r_is_div) begin
              r_lo <= r_dz ? '1 : w_quo;
              r_hi <= w_rem;
            end else begin
              r_hi <= w_prod[2*WORD_W-1:WORD_W];
              r_lo <= w_prod[WORD_W-1:0];
            end
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy  = (r_state != S_IDLE);
  assign stall = (mf_req || start) && busy;
  assign done  = r_done;
  assign hi    = r_hi;
  assign lo    = r_lo;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: two instances (MUL_BITS 1 and 2) share stimulus and
// are checked every cycle against an arithmetic latency/result model.
module tb_ex_muldiv_unit;
  import cpu_types_pkg::*;

  localparam int W = 32;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       flush = 1'b0;
  logic       start = 1'b0;
  logic       mf_req = 1'b0;
  muldiv_op_t op = MD_MULTU;
  logic [W-1:0] opa = '0;
  logic [W-1:0] opb = '0;

  logic [1:0]        busy, stall, done;
  logic [1:0][W-1:0] hiv, lov;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  ex_muldiv_unit #(.WORD_W(W), .MUL_BITS(1)) dut0 (
    .CLK(CLK), .nRST(nRST), .flush(flush), .start(start), .op(op),
    .opa(opa), .opb(opb), .mf_req(mf_req),
    .busy(busy[0]), .stall(stall[0]), .done(done[0]), .hi(hiv[0]), .lo(lov[0])
  );

  ex_muldiv_unit #(.WORD_W(W), .MUL_BITS(2)) dut1 (
    .CLK(CLK), .nRST(nRST), .flush(flush), .start(start), .op(op),
    .opa(opa), .opb(opb), .mf_req(mf_req),
    .busy(busy[1]), .stall(stall[1]), .done(done[1]), .hi(hiv[1]), .lo(lov[1])
  );

  // Architectural result of one operation, from plain integer arithmetic
  function automatic void computeResult(input muldiv_op_t o, input logic [W-1:0] a,
                                        input logic [W-1:0] b,
                                        output logic [W-1:0] rh, output logic [W-1:0] rl);
    logic [2*W-1:0] p;
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    rh = '0;
    rl = '0;
    case (o)
      MD_MULTU: begin
        p  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        rh = p[2*W-1:W];
        rl = p[W-1:0];
      end
      MD_MULT: begin
        p  = sa * sb;
        rh = p[2*W-1:W];
        rl = p[W-1:0];
      end
      MD_DIVU: begin
        if (b == '0) begin rl = '1; rh = a; end
        else begin rl = a / b; rh = a % b; end
      end
      MD_DIV: begin
        if (b == '0) begin
          rl = '1;
          rh = a;
        end else begin
          p  = sa / sb;
          rl = p[W-1:0];
          p  = sa % sb;
          rh = p[W-1:0];
        end
      end
      default: ;
    endcase
  endfunction

  // Model: per instance, cycles left until the commit edge plus the pending result
  int           m_left [2] = '{0, 0};
  logic [W-1:0] m_hi   [2] = '{default: '0};
  logic [W-1:0] m_lo   [2] = '{default: '0};
  logic [W-1:0] m_phi  [2] = '{default: '0};
  logic [W-1:0] m_plo  [2] = '{default: '0};
  logic         m_done [2] = '{default: 1'b0};

  always @(posedge CLK) begin
    logic [W-1:0] th, tl;
    for (int i = 0; i < 2; i++) begin
      if (!nRST) begin
        m_left[i] <= 0;
        m_hi[i]   <= '0;
        m_lo[i]   <= '0;
        m_done[i] <= 1'b0;
      end else begin
        m_done[i] <= 1'b0;
        if (m_left[i] > 0) begin
          if (flush) m_left[i] <= 0;
          else if (m_left[i] == 1) begin
            m_hi[i]   <= m_phi[i];
            m_lo[i]   <= m_plo[i];
            m_done[i] <= 1'b1;
            m_left[i] <= 0;
          end else m_left[i] <= m_left[i] - 1;
        end else if (start && !flush) begin
          case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
              computeResult(op, opa, opb, th, tl);
              m_phi[i]  <= th;
              m_plo[i]  <= tl;
              if (op == MD_MULT || op == MD_MULTU) m_left[i] <= (i == 0) ? 33 : 17;
              else m_left[i] <= 33;
            end
            MD_MTHI: m_hi[i] <= opa;
            MD_MTLO: m_lo[i] <= opa;
            default: ;
          endcase
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model
  always @(negedge CLK) begin
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("dut%0d.busy", i), 32'(busy[i]), 32'(m_left[i] > 0));
      checkOutput($sformatf("dut%0d.stall", i), 32'(stall[i]),
                  32'((mf_req || start) && (m_left[i] > 0)));
      checkOutput($sformatf("dut%0d.done", i), 32'(done[i]), 32'(m_done[i]));
      checkOutput($sformatf("dut%0d.hi", i), hiv[i], m_hi[i]);
      checkOutput($sformatf("dut%0d.lo", i), lov[i], m_lo[i]);
    end
  end

  task automatic waitIdle();
    int c = 0;
    while (busy != 2'b00 && c < 200) begin
      @(posedge CLK); #1;
      c++;
    end
    checkOutput("idle.wait", 32'(busy), 32'(0));
  endtask

  task automatic applyStimulus(input muldiv_op_t o, input logic [W-1:0] a, input logic [W-1:0] b);
    waitIdle();
    start = 1'b1;
    op    = o;
    opa   = a;
    opb   = b;
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  task automatic waitDone0(output int cyc);
    cyc = 0;
    while (!done[0] && cyc < 100) begin
      @(posedge CLK); #1;
      cyc++;
    end
  endtask

  task automatic runOp(input muldiv_op_t o, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat0, output int lat1, output int nbusy);
    int c = 0;
    applyStimulus(o, a, b);
    lat0  = -1;
    lat1  = -1;
    nbusy = busy[0] ? 1 : 0;
    while ((lat0 < 0 || lat1 < 0) && c < 100) begin
      @(posedge CLK); #1;
      c++;
      if (busy[0]) nbusy++;
      if (done[0] && lat0 < 0) lat0 = c;
      if (done[1] && lat1 < 0) lat1 = c;
    end
  endtask

  int l0, l1, nb, c, seen, stallLow;

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("reset.hi", hiv[0], 32'h0);
    checkOutput("reset.lo", lov[0], 32'h0);
    checkOutput("reset.busy", 32'(busy), 32'h0);
    nRST = 1'b1;

    runOp(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, l0, l1, nb);
    checkOutput("multu.lat0", 32'(l0), 32'd33);
    checkOutput("multu.lat1", 32'(l1), 32'd17);
    checkOutput("multu.busycycles", 32'(nb), 32'd33);
    checkOutput("multu.hi", hiv[0], 32'hFFFFFFFE);
    checkOutput("multu.lo", lov[0], 32'h00000001);

    runOp(MD_MULT, 32'hFFFFFFF9, 32'd3, l0, l1, nb);
    checkOutput("mult.lat1", 32'(l1), 32'd17);
    checkOutput("mult.hi", hiv[0], 32'hFFFFFFFF);
    checkOutput("mult.lo", lov[0], 32'hFFFFFFEB);
    checkOutput("mult.hi.mb2", hiv[1], 32'hFFFFFFFF);
    checkOutput("mult.lo.mb2", lov[1], 32'hFFFFFFEB);

    runOp(MD_DIV, 32'hFFFFFFF9, 32'd2, l0, l1, nb);
    checkOutput("div.lat0", 32'(l0), 32'd33);
    checkOutput("div.lo", lov[0], 32'hFFFFFFFD);
    checkOutput("div.hi", hiv[0], 32'hFFFFFFFF);

    runOp(MD_DIVU, 32'd100, 32'd7, l0, l1, nb);
    checkOutput("divu.lo", lov[0], 32'd14);
    checkOutput("divu.hi", hiv[0], 32'd2);

    runOp(MD_DIV, 32'h12345678, 32'h0, l0, l1, nb);
    checkOutput("div0.lat0", 32'(l0), 32'd33);
    checkOutput("div0.lo", lov[0], 32'hFFFFFFFF);
    checkOutput("div0.hi", hiv[0], 32'h12345678);

    runOp(MD_DIV, 32'h80000000, 32'hFFFFFFFF, l0, l1, nb);
    checkOutput("divovf.lo", lov[0], 32'h80000000);
    checkOutput("divovf.hi", hiv[0], 32'h0);

    runOp(MD_DIV, 32'hFFFFFFF9, 32'h0, l0, l1, nb);
    checkOutput("div0neg.hi", hiv[0], 32'hFFFFFFF9);
    runOp(MD_DIV, 32'd7, 32'hFFFFFFFE, l0, l1, nb);
    runOp(MD_MULT, 32'h80000000, 32'h80000000, l0, l1, nb);
    runOp(MD_DIVU, 32'hFFFFFFFF, 32'd16, l0, l1, nb);

    // Flush partway through a multiply
    applyStimulus(MD_MTHI, 32'hAAAA, 32'h0);
    applyStimulus(MD_MTLO, 32'h5555, 32'h0);
    applyStimulus(MD_MULTU, 32'd5, 32'd5);
    repeat (9) @(posedge CLK);
    #1;
    flush = 1'b1;
    @(posedge CLK); #1;
    flush = 1'b0;
    checkOutput("flush.busy", 32'(busy), 32'h0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge CLK); #1;
      if (done != 2'b00) seen++;
    end
    checkOutput("flush.nodone", 32'(seen), 32'h0);
    checkOutput("flush.hi", hiv[0], 32'hAAAA);
    checkOutput("flush.lo", lov[0], 32'h5555);

    // Flush on the edge leaving FIX for dut0; dut1 has already committed
    applyStimulus(MD_MULTU, 32'd3, 32'd3);
    repeat (32) @(posedge CLK);
    #1;
    flush = 1'b1;
    @(posedge CLK); #1;
    flush = 1'b0;
    checkOutput("fixflush.done", 32'(done[0]), 32'h0);
    checkOutput("fixflush.hi", hiv[0], 32'hAAAA);
    checkOutput("fixflush.lo", lov[0], 32'h5555);
    checkOutput("fixflush.lo.mb2", lov[1], 32'd9);

    // Start together with flush in IDLE is dropped
    waitIdle();
    start = 1'b1; flush = 1'b1; op = MD_MTHI; opa = 32'h1234;
    @(posedge CLK); #1;
    start = 1'b0; flush = 1'b0;
    checkOutput("flushstart.hi", hiv[0], 32'hAAAA);

    // MFHI/MFLO stall during a divide
    applyStimulus(MD_DIVU, 32'd1000, 32'd10);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    mf_req = 1'b1;
    c = 0;
    stallLow = 0;
    while (!done[0] && c < 100) begin
      #1;
      if (!stall[0]) stallLow++;
      @(posedge CLK); #1;
      c++;
    end
    #1;
    checkOutput("stall.cycles", 32'(c), 32'd31);
    checkOutput("stall.neverlow", 32'(stallLow), 32'h0);
    checkOutput("stall.donecycle", 32'(stall[0]), 32'h0);
    checkOutput("stall.lo", lov[0], 32'd100);
    mf_req = 1'b0;

    // Second MULT held while busy is only accepted once the unit is idle
    applyStimulus(MD_MULTU, 32'd7, 32'd6);
    start = 1'b1; op = MD_MULT; opa = 32'hFFFFFFFE; opb = 32'hFFFFFFFD;
    #1;
    checkOutput("hold.stall", 32'(stall[0]), 32'h1);
    waitDone0(c);
    checkOutput("hold.lat", 32'(c), 32'd33);
    checkOutput("hold.first.lo", lov[0], 32'd42);
    checkOutput("hold.idle", 32'(busy[0]), 32'h0);
    @(posedge CLK); #1;
    checkOutput("hold.accepted", 32'(busy[0]), 32'h1);
    start = 1'b0;
    waitDone0(c);
    checkOutput("hold.second.lat", 32'(c), 32'd33);
    checkOutput("hold.second.hi", hiv[0], 32'h0);
    checkOutput("hold.second.lo", lov[0], 32'd6);

    waitIdle();
    repeat (3) @(posedge CLK);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
